// File: rtl/conversor_bcd_binario.sv
// conversor_bcd_binario
// Sequential two-digit BCD-to-binary converter (00-99) using an iterative
// reverse double-dabble. The packed BCD value is accepted on a start request,
// converted one shift per cycle over 7 cycles, and the binary result is
// published together with a one-cycle done pulse. Digits above 9 saturate the
// result to 99 and raise the error flag.
//
// Ports:
//   clock    in   1  system clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   iniciar  in   1  start request, honoured only when idle
//   bcd      in   8  packed BCD input, [7:4] tens, [3:0] units
//   ocupado  out  1  conversion in progress
//   pronto   out  1  one-cycle pulse when binario/erro are updated
//   binario  out  7  binary result, held between conversions
//   erro     out  1  last captured bcd had a digit > 9, held with binario
module conversor_bcd_binario (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] bcd,
  output logic       ocupado,
  output logic       pronto,
  output logic [6:0] binario,
  output logic       erro
);

  typedef enum logic {
    OCIOSO   = 1'b0,
    CONVERTE = 1'b1
  } estado_t;

  estado_t     estado;
  logic [2:0]  passo;     // step counter, 0..6
  logic [14:0] desloc;    // {tens, units, binary} shift register
  logic        invalido;  // captured bcd had a digit > 9
  logic [14:0] proximo;   // shift register after the current step

  // One reverse double-dabble step: shift right, then any BCD nibble that
  // reads 8 or more received a bit worth 5 (10/2) but is weighted as 8, so
  // take 3 back off it.
  function automatic logic [14:0] passo_dabble(input logic [14:0] v);
    logic [14:0] s;
    s = v >> 1;
    if (s[14:11] >= 4'd8) begin
      s[14:11] = s[14:11] - 4'd3;
    end else begin
      s[14:11] = s[14:11];
    end
    if (s[10:7] >= 4'd8) begin
      s[10:7] = s[10:7] - 4'd3;
    end else begin
      s[10:7] = s[10:7];
    end
    return s;
  endfunction

  // Next value of the shift register for the step being executed.
  always_comb begin
    proximo = passo_dabble(desloc);
  end

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= OCIOSO;
      passo    <= 3'd0;
      desloc   <= 15'd0;
      invalido <= 1'b0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
      binario  <= 7'd0;
      erro     <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          pronto <= 1'b0;
          if (iniciar) begin
            desloc   <= {bcd, 7'd0};
            invalido <= (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
            passo    <= 3'd0;
            ocupado  <= 1'b1;
            estado   <= CONVERTE;
          end else begin
            ocupado <= 1'b0;
          end
        end
        CONVERTE: begin
          desloc <= proximo;
          if (passo == 3'd6) begin
            // Seventh shift lands the full binary value in the low bits.
            estado  <= OCIOSO;
            ocupado <= 1'b0;
            pronto  <= 1'b1;
            if (invalido) begin
              binario <= 7'd99;
              erro    <= 1'b1;
            end else begin
              binario <= proximo[6:0];
              erro    <= 1'b0;
            end
          end else begin
            passo  <= passo + 3'd1;
            pronto <= 1'b0;
          end
        end
        default: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
          pronto  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bcd_binario.sv
// Self-checking bench for conversor_bcd_binario: randomized and directed
// stimulus compared against an arithmetic reference (10*tens + units, with
// saturation to 99 and the error flag for digits above 9).
module tb_conversor_bcd_binario;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [7:0] bcd;
  logic       ocupado;
  logic       pronto;
  logic [6:0] binario;
  logic       erro;

  int checks;
  int errors;

  conversor_bcd_binario dut (
    .clock   (clock),
    .reset   (reset),
    .iniciar (iniciar),
    .bcd     (bcd),
    .ocupado (ocupado),
    .pronto  (pronto),
    .binario (binario),
    .erro    (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts one comparison and reports it when it does not hold.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: returns {erro, binario}.
  function automatic logic [7:0] ref_conv(input logic [7:0] code);
    int t;
    int u;
    t = code[7:4];
    u = code[3:0];
    if (t > 9 || u > 9) return {1'b1, 7'd99};
    return {1'b0, 7'(t * 10 + u)};
  endfunction

  // Wait (bounded) for pronto, counting negedges; checks ocupado while waiting.
  task automatic wait_pronto(output int n);
    n = 0;
    while (pronto !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
      if (pronto !== 1'b1) check("ocupado_busy", ocupado, 1);
    end
  endtask

  // Starts one conversion from a negedge with the DUT able to accept and
  // returns on the negedge where pronto is seen.
  task automatic run_conv(input logic [7:0] code, input bit keep, input bit noise);
    int n;
    logic [7:0] e;
    e = ref_conv(code);
    bcd = code;
    iniciar = 1'b1;
    @(negedge clock);
    check("ocupado_accept", ocupado, 1);
    check("pronto_low", pronto, 0);
    if (!keep) iniciar = 1'b0;
    if (noise) bcd = 8'($urandom);
    wait_pronto(n);
    check("latency", n, 7);
    check("binario", binario, e[6:0]);
    check("erro", erro, e[7]);
    check("ocupado_done", ocupado, 0);
  endtask

  initial begin
    int n;
    int cnt;
    int last;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    iniciar = 1'b0;
    bcd     = 8'h00;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ocupado", ocupado, 0);
    check("rst_pronto", pronto, 0);
    check("rst_binario", binario, 0);
    check("rst_erro", erro, 0);
    reset = 1'b0;
    @(negedge clock);

    // Basic conversion
    run_conv(8'h47, 1'b0, 1'b0);
    @(negedge clock);
    check("pronto_one_cycle", pronto, 0);
    check("binario_hold", binario, 47);

    // Back-to-back sweep of all valid codes, bcd scrambled mid-conversion
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        run_conv({4'(t), 4'(u)}, 1'b1, 1'b1);
      end
    end
    iniciar = 1'b0;
    @(negedge clock);

    // Invalid digits and recovery
    run_conv(8'hA5, 1'b0, 1'b0);
    run_conv(8'h3F, 1'b0, 1'b0);
    run_conv(8'h12, 1'b0, 1'b0);
    run_conv(8'h9A, 1'b0, 1'b0);
    run_conv(8'hA0, 1'b0, 1'b0);
    run_conv(8'hFF, 1'b0, 1'b0);
    run_conv(8'h99, 1'b0, 1'b0);
    run_conv(8'h00, 1'b0, 1'b0);

    // Random codes (valid and invalid)
    for (int i = 0; i < 30; i++) begin
      run_conv(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    iniciar = 1'b0;
    @(negedge clock);

    // Start while busy is ignored and not queued
    bcd = 8'h25;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    n = 0;
    while (pronto !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
      if (n == 2) begin
        bcd = 8'h80;
        iniciar = 1'b1;
      end else if (n == 3) begin
        iniciar = 1'b0;
        bcd = 8'h0F;
      end
    end
    check("busy_latency", n, 7);
    check("busy_binario", binario, 25);
    check("busy_erro", erro, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (pronto === 1'b1 || ocupado === 1'b1) cnt++;
    end
    check("no_queued_start", cnt, 0);
    check("busy_hold", binario, 25);

    // Reset mid-conversion
    bcd = 8'h63;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_ocupado", ocupado, 0);
    check("midrst_binario", binario, 0);
    check("midrst_erro", erro, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (pronto === 1'b1 || ocupado === 1'b1 || binario !== 7'd0) cnt++;
    end
    check("midrst_quiet", cnt, 0);
    run_conv(8'h08, 1'b0, 1'b0);
    @(negedge clock);

    // Held start: one conversion every 8 cycles
    bcd = 8'h99;
    iniciar = 1'b1;
    cnt = 0;
    last = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (pronto === 1'b1) begin
        cnt++;
        check("held_gap", i - last, 8);
        check("held_binario", binario, 99);
        last = i;
      end
    end
    check("held_count", cnt, 5);
    iniciar = 1'b0;
    repeat (10) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
